// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared widths, reset/vector defaults and SEQ_state encodings
// for the program-counter sequencer. Revision: 1.0
`default_nettype none

package pc_seq_pkg;

  localparam int         SEQ_PC_W       = 8;
  localparam logic [7:0] SEQ_RESET_PC   = 8'h00;
  localparam logic [7:0] SEQ_EXC_VECTOR = 8'hF0;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'b00,
    ST_LOAD   = 2'b01,
    ST_HALT   = 2'b10
  } seq_state_e;

  localparam logic [1:0] SEQ_ACTIVE = 2'b00;
  localparam logic [1:0] SEQ_LOAD   = 2'b01;
  localparam logic [1:0] SEQ_HALT   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/btn_sync.sv
// btn_sync: 2-flop synchronizer for an asynchronous button level followed by
// a one-cycle rising-edge pulse. Revision: 1.0
`default_nettype none

module btn_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC/EPC owner, next-PC select, load/step/run control and
// exception stop or vector (macro SEQ_EXC_VECTOR_EN selects vectoring). Revision: 1.0
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W       = SEQ_PC_W,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(SEQ_RESET_PC),
  parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(SEQ_EXC_VECTOR)
) (
  input  logic            SYS_clk,
  input  logic            SYS_rst,
  input  logic            SYS_load,
  input  logic [PC_W-1:0] SYS_pc_val,
  input  logic            SYS_step,
  input  logic            SYS_run_mode,
  input  logic            EH_flag,
  input  logic            Jump,
  input  logic            Branch,
  input  logic            Zero,
  input  logic [PC_W-1:0] Imm_branch,
  input  logic [PC_W-1:0] Imm_jump,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] EPC,
  output logic            Commit_en,
  output logic            EH_led,
  output logic [1:0]      SEQ_state
);

`ifdef SEQ_EXC_VECTOR_EN
  localparam logic VEC_EN = 1'b1;
`else
  localparam logic VEC_EN = 1'b0;
`endif

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            led_q, led_d;
  logic [1:0]      state_q, state_d;

  logic            load_edge;
  logic            step_edge;
  logic            advance;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] next_pc;

  btn_sync u_load_sync (
    .clk_i   (SYS_clk),
    .rst_i   (SYS_rst),
    .btn_i   (SYS_load),
    .pulse_o (load_edge)
  );

  btn_sync u_step_sync (
    .clk_i   (SYS_clk),
    .rst_i   (SYS_rst),
    .btn_i   (SYS_step),
    .pulse_o (step_edge)
  );

  assign pc_inc = pc_q + PC_ONE;

  always_comb begin
    next_pc = pc_inc;
    if (Jump) begin
      next_pc = pc_inc + Imm_jump;
    end else if (Branch && Zero) begin
      next_pc = pc_inc + Imm_branch;
    end
  end

  assign advance   = (state_q == SEQ_ACTIVE) && (SYS_run_mode || step_edge);
  assign Commit_en = advance && !EH_flag;

  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    led_d   = led_q;
    state_d = state_q;
    if (load_edge) begin
      pc_d    = SYS_pc_val;
      led_d   = 1'b0;
      state_d = SEQ_LOAD;
    end else if (advance && EH_flag) begin
      epc_d   = pc_q;
      led_d   = 1'b1;
      pc_d    = VEC_EN ? EXC_VECTOR : pc_q;
      state_d = VEC_EN ? SEQ_ACTIVE : SEQ_HALT;
    end else if (advance) begin
      pc_d = next_pc;
    end else if (state_q != SEQ_ACTIVE && state_q != SEQ_HALT) begin
      // LOAD lasts one cycle; the unused encoding also falls back to ACTIVE
      state_d = SEQ_ACTIVE;
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) begin
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      led_q   <= 1'b0;
      state_q <= SEQ_ACTIVE;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      led_q   <= led_d;
      state_q <= state_d;
    end
  end

  assign PC        = pc_q;
  assign EPC       = epc_q;
  assign EH_led    = led_q;
  assign SEQ_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; stimulus pushes model predictions per
// cycle, a negedge monitor pops and compares against the DUT outputs.
`default_nettype none

module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst, load, step, run, eh, jmp, br, zr;
  logic [7:0] pcv, immb, immj;
  logic [7:0] pc_o, epc_o;
  logic       commit_o, led_o;
  logic [1:0] st_o;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .SYS_clk      (clk),
    .SYS_rst      (rst),
    .SYS_load     (load),
    .SYS_pc_val   (pcv),
    .SYS_step     (step),
    .SYS_run_mode (run),
    .EH_flag      (eh),
    .Jump         (jmp),
    .Branch       (br),
    .Zero         (zr),
    .Imm_branch   (immb),
    .Imm_jump     (immj),
    .PC           (pc_o),
    .EPC          (epc_o),
    .Commit_en    (commit_o),
    .EH_led       (led_o),
    .SEQ_state    (st_o)
  );

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] epc;
    logic       led;
    logic [1:0] st;
    logic       commit;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: architectural state plus the sampled button history,
  // most recent edge first.
  logic [7:0] m_pc, m_epc;
  logic       m_led;
  int         m_st;          // 0 active, 1 load, 2 halt
  logic [2:0] m_hl, m_hs;
  bit         m_valid = 0;

`ifdef SEQ_EXC_VECTOR_EN
  localparam bit VECTORED = 1;
`else
  localparam bit VECTORED = 0;
`endif

  task automatic model_cycle();
    bit   le, se, adv;
    exp_t e;
    le  = m_hl[1] && !m_hl[2];
    se  = m_hs[1] && !m_hs[2];
    adv = (m_st == 0) && (run || se);
    if (m_valid) begin
      e.pc = m_pc; e.epc = m_epc; e.led = m_led;
      e.st = 2'(m_st); e.commit = adv && !eh;
      sb.push_back(e);
    end
    if (rst) begin
      m_pc = 8'h00; m_epc = 8'h00; m_led = 0; m_st = 0;
      m_hl = '0; m_hs = '0; m_valid = 1;
    end else begin
      if (le) begin
        m_pc = pcv; m_led = 0; m_st = 1;
      end else if (adv && eh) begin
        m_epc = m_pc; m_led = 1;
        if (VECTORED) m_pc = 8'hF0;
        else m_st = 2;
      end else if (adv) begin
        if (jmp)           m_pc = 8'((int'(m_pc) + 1 + int'(immj)) % 256);
        else if (br && zr) m_pc = 8'((int'(m_pc) + 1 + int'(immb)) % 256);
        else               m_pc = 8'((int'(m_pc) + 1) % 256);
      end else if (m_st == 1) begin
        m_st = 0;
      end
      m_hl = {m_hl[1:0], load};
      m_hs = {m_hs[1:0], step};
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic [7:0] v,
                     input logic s, input logic rm, input logic e,
                     input logic j, input logic b, input logic z,
                     input logic [7:0] ib, input logic [7:0] ij);
    @(posedge clk); #1;
    rst = r; load = l; pcv = v; step = s; run = rm; eh = e;
    jmp = j; br = b; zr = z; immb = ib; immj = ij;
    model_cycle();
  endtask

  task automatic idle(input int n, input logic rm);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, rm, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  // Load value v with run_mode off; leaves the sequencer ACTIVE at PC=v.
  task automatic do_load(input logic [7:0] v);
    for (int i = 0; i < 3; i++) cyc(0, 1, v, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, v, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    idle(2, 0);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("PC",        pc_o,            e.pc);
      chk("EPC",       epc_o,           e.epc);
      chk("EH_led",    {7'd0, led_o},   {7'd0, e.led});
      chk("SEQ_state", {6'd0, st_o},    {6'd0, e.st});
      chk("Commit_en", {7'd0, commit_o},{7'd0, e.commit});
    end
  end

  initial begin
    logic       rl, rs, rr;
    rst = 1; load = 0; step = 0; run = 0; eh = 0;
    jmp = 0; br = 0; zr = 0; pcv = 0; immb = 0; immj = 0;
    // reset then free run from 00
    cyc(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    idle(6, 1);
    // branch backwards with wrap, sequential wrap, jump
    do_load(8'h10);
    cyc(0, 0, 8'h00, 0, 1, 0, 0, 1, 1, 8'hFC, 8'h00);
    do_load(8'hFF);
    idle(2, 1);
    do_load(8'h20);
    cyc(0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00, 8'h05);
    // single step: long press retires one instruction
    do_load(8'h00);
    for (int i = 0; i < 10; i++) cyc(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    idle(3, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    idle(3, 0);
    // exception in a commit cycle at PC=07, then steps
    do_load(8'h07);
    cyc(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    idle(4, 0);
    do_load(8'h3A);
    // reset coincides with load_edge and an exception
    idle(2, 1);
    cyc(0, 1, 8'h55, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 1, 8'h55, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(1, 1, 8'h55, 0, 1, 1, 0, 0, 0, 8'h00, 8'h00);
    idle(3, 1);
    // randomized phase; buttons hold levels for several cycles
    rl = 0; rs = 0; rr = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0)  rl = ~rl;
      if ($urandom_range(0, 3) == 0)  rs = ~rs;
      if ($urandom_range(0, 19) == 0) rr = ~rr;
      cyc(($urandom_range(0, 199) == 0), rl, 8'($urandom), rs, rr,
          ($urandom_range(0, 11) == 0), 1'($urandom), 1'($urandom),
          1'($urandom), 8'($urandom), 8'($urandom));
    end
    idle(2, 0);
    @(negedge clk); #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer and execution controller for the single-cycle MIPS datapath. Owns PC and EPC and computes next-PC (sequential, branch, jump). Also handles PC load from switches, free-run/single-step control, and the exception stop or vector. Its commit strobe gates every architectural write (register file, DMEM), so the datapath only retires an instruction when this block advances.

## Interface
Parameters:
- PC_W, 8, PC/EPC width; all PC arithmetic is modulo 2^PC_W
- RESET_PC, 8'h00, PC value after reset
- EXC_VECTOR, 8'hF0, exception target (used only with SEQ_EXC_VECTOR_EN)

Ports:
- SYS_clk  in  1  system clock; all state updates on rising edge
- SYS_rst  in  1  reset, synchronous, active-high
- SYS_load  in  1  load request, asynchronous button level, active-high
- SYS_pc_val  in  PC_W  value loaded into PC on a load request
- SYS_step  in  1  single-step request, asynchronous button level, active-high
- SYS_run_mode  in  1  1 = free run; 0 = one instruction per SYS_step edge
- EH_flag  in  1  combinational exception for the current instruction
- Jump, Branch, Zero  in  1 each  control and ALU-zero for the current instruction
- Imm_branch  in  PC_W  sign-extended branch offset, low PC_W bits
- Imm_jump  in  PC_W  jump offset, low PC_W bits
- PC  out  PC_W  current instruction address (registered)
- EPC  out  PC_W  address of the last faulting instruction (registered)
- Commit_en  out  1  combinational; gates Reg_Write and Mem_Write
- EH_led  out  1  sticky exception indicator (registered)
- SEQ_state  out  2  00 ACTIVE, 01 LOAD, 10 HALT (for LCD display)

## Operation
- SYS_load and SYS_step each pass through a 2-flop synchronizer.
- A rising-edge detector on each produces load_edge and step_edge, one cycle each.
- advance = (state==ACTIVE) & (SYS_run_mode | step_edge).
- Commit_en = advance & ~EH_flag.
- next_seq = PC+1.
- Branch target = PC+1+Imm_branch; jump target = PC+1+Imm_jump. Both wrap modulo 2^PC_W.
- Next-PC select: Jump, then (Branch & Zero), then next_seq.
- Priority per edge: SYS_rst > load_edge > exception > advance > hold.
- Reset: PC=RESET_PC, EPC=0, EH_led=0, state=ACTIVE, synchronizer and edge flops cleared.
- ACTIVE:
  - load_edge: PC<=SYS_pc_val, EH_led<=0, state<=LOAD.
  - advance & EH_flag: EPC<=PC, EH_led<=1, exception action (see Configuration).
  - advance & ~EH_flag: PC<=next-PC.
  - Otherwise hold.
- LOAD: one cycle, Commit_en=0, PC holds the loaded value, then ACTIVE. A load_edge in LOAD reloads and stays in LOAD.
- HALT: Commit_en=0, PC/EPC hold, step_edge and run_mode ignored. Exit only via load_edge (to LOAD) or SYS_rst.
- step_edge while SYS_run_mode=1 is a no-op. step_edge outside ACTIVE is dropped, not queued.

## Timing
- PC and EPC change only on SYS_clk rising edges. Commit_en is same-cycle combinational from registered state plus inputs.
- Load latency: SYS_load rises before edge k. s1 is set at k, s2 at k+1, PC==SYS_pc_val after edge k+2, and SEQ_state=LOAD for the following cycle.
- Step latency is the same: 3 edges from button to PC change. Exactly one instruction retires per button press, however long it is held.
- Free run: one instruction per cycle, Commit_en=1 continuously absent exceptions.
- EH_flag sampled in a commit cycle: Commit_en deasserts the same cycle, so no register or DMEM write. EPC updates at the next edge.
- SYS_rst in the same cycle as load_edge or an exception: reset wins, EPC=0.

## Configuration
- SEQ_EXC_VECTOR_EN defined: on exception, PC<=EXC_VECTOR and state stays ACTIVE; execution continues at the handler. HALT is unreachable.
- SEQ_EXC_VECTOR_EN undefined: on exception, PC holds the faulting address and state<=HALT.

## Structure
- Package pc_seq_pkg holds:
  - the state enum (ACTIVE=2'b00, LOAD=2'b01, HALT=2'b10)
  - PC_W default, RESET_PC and EXC_VECTOR defaults, and the SEQ_state encoding constants
- Sub-module btn_sync: 2-flop synchronizer plus rising-edge pulse, synchronous active-high reset. Instantiated twice, for load and step.

## Test plan
- Reset, run_mode=1, no branches, 5 cycles -> PC 00,01,02,03,04,05; Commit_en=1 each cycle.
- PC=10, Branch=1, Zero=1, Imm_branch=8'hFC -> next PC=0D. PC=FF sequential -> wraps to 00. PC=20, Jump=1, Imm_jump=05 -> 26.
- run_mode=0, SYS_step held high 10 cycles -> exactly one advance after 3 edges, PC 00->01. Release and press again -> 02.
- SYS_load pulse, SYS_pc_val=8'h3A -> PC=3A after 3 edges, SEQ_state=01 one cycle then 00, EH_led cleared.
- PC=07, EH_flag=1 in a commit cycle -> Commit_en=0 that cycle, EPC=07, EH_led=1. Without the macro: PC stays 07, SEQ_state=10, steps ignored until load. With the macro: PC=F0, SEQ_state=00.
- SYS_rst asserted in the same cycle as EH_flag and load_edge -> PC=00, EPC=00, EH_led=0, SEQ_state=00.
